mmio_data_memory: RTL and testbench

Parametrised data memory and memory-mapped peripheral block for the pipelined MIPS core. It serves load/store accesses on the data port and holds:
- a word RAM with byte-enable writes;
- TIMER_CH independent reload timers with interrupt flags;
- LED and digit registers;
- buffered UART receive and transmit FIFOs that connect to external uart_rx/uart_tx cores through valid/ready handshakes.

It sits in the MEM stage, with interrupt outputs routed to the exception logic.

---
 rtl/mmio_data_memory_if.sv | 13 +
 rtl/mmio_data_memory.sv | 226 ++++++++++++++++++++++
 tb/tb_mmio_data_memory.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_data_memory_if.sv
// Data-port bundle between the MEM stage and the data memory / MMIO block.
// The master drives the address, store data and strobes; the slave returns load data.
interface mmio_data_memory_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] rdata;

   modport master (output addr, wdata, be, mem_read, mem_write, input rdata);
   modport slave  (input addr, wdata, be, mem_read, mem_write, output rdata);
endinterface

// File: rtl/mmio_data_memory.sv
// Word RAM plus memory-mapped LEDs, digits, reload timers and buffered UART FIFOs
// for the MEM stage of the pipelined MIPS core.
module mmio_data_memory #(
   parameter int RAM_AW   = 9,
   parameter int TIMER_CH = 2,
   parameter int FIFO_AW  = 4
) (
   input  logic                clk,
   input  logic                reset,
   mmio_data_memory_if.slave   bus,
   input  logic [31:0]         clk_count,
   output logic [31:0]         leds,
   output logic [31:0]         digits,
   output logic [TIMER_CH-1:0] irq_timer,
   output logic                irq_rx,
   input  logic                rx_valid,
   input  logic [7:0]          rx_data,
   output logic                tx_valid,
   output logic [7:0]          tx_data,
   input  logic                tx_ready
);
   localparam int FIFO_DEPTH = 2 ** FIFO_AW;

   localparam logic [7:0] OFF_SYSCLK = 8'h00;
   localparam logic [7:0] OFF_LED    = 8'h04;
   localparam logic [7:0] OFF_DIGIT  = 8'h08;
   localparam logic [7:0] OFF_STAT   = 8'h0C;
   localparam logic [7:0] OFF_RX     = 8'h10;
   localparam logic [7:0] OFF_TX     = 8'h14;
   localparam logic [7:0] OFF_CTRL   = 8'h18;

   function automatic logic [7:0] timerBase(input int k);
      return 8'(32 + 16 * k);
   endfunction

   logic              isPeriph;
   logic [7:0]        offset;
   logic [RAM_AW-1:0] ramIdx;
   logic              periphRd;
   logic              periphWr;
   logic              ramWr;
   logic              unusedAddrBits;

   assign isPeriph       = (bus.addr[31:28] == 4'h4);
   assign offset         = bus.addr[7:0];
   assign ramIdx         = bus.addr[RAM_AW+1:2];
   assign periphRd       = bus.mem_read && isPeriph;
   assign periphWr       = bus.mem_write && isPeriph;
   assign ramWr          = bus.mem_write && !isPeriph;
   assign unusedAddrBits = ^bus.addr[27:RAM_AW+2];

   // RAM has no reset so it maps onto block RAM; the read port is read-first.
   logic [31:0] ram [2**RAM_AW];
   logic [31:0] ramQ_q;

   always_ff @(posedge clk) begin
      if (ramWr) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.be[b]) ram[ramIdx][8*b +: 8] <= bus.wdata[8*b +: 8];
         end
      end
      if (bus.mem_read && !isPeriph) ramQ_q <= ram[ramIdx];
   end

   logic [7:0]       rxMem [FIFO_DEPTH];
   logic [7:0]       txMem [FIFO_DEPTH];
   logic [FIFO_AW:0] rxWrPtr_q, rxRdPtr_q, txWrPtr_q, txRdPtr_q;
   logic             rxEmpty, rxFull, txEmpty, txFull;
   logic             rxPush, rxPop, txPush, txPop, txPushReq;
   logic             statWr;

   assign rxEmpty   = (rxWrPtr_q == rxRdPtr_q);
   assign rxFull    = (rxWrPtr_q[FIFO_AW] != rxRdPtr_q[FIFO_AW]) &&
                      (rxWrPtr_q[FIFO_AW-1:0] == rxRdPtr_q[FIFO_AW-1:0]);
   assign txEmpty   = (txWrPtr_q == txRdPtr_q);
   assign txFull    = (txWrPtr_q[FIFO_AW] != txRdPtr_q[FIFO_AW]) &&
                      (txWrPtr_q[FIFO_AW-1:0] == txRdPtr_q[FIFO_AW-1:0]);
   assign rxPush    = rx_valid && !rxFull;
   assign rxPop     = periphRd && (offset == OFF_RX) && !rxEmpty;
   assign txPushReq = periphWr && (offset == OFF_TX);
   assign txPush    = txPushReq && !txFull;
   assign txPop     = !txEmpty && tx_ready;
   assign statWr    = periphWr && (offset == OFF_STAT);

   assign tx_valid = !txEmpty;
   assign tx_data  = txMem[txRdPtr_q[FIFO_AW-1:0]];

   always_ff @(posedge clk) begin
      if (rxPush) rxMem[rxWrPtr_q[FIFO_AW-1:0]] <= rx_data;
      if (txPush) txMem[txWrPtr_q[FIFO_AW-1:0]] <= bus.wdata[7:0];
   end

   // Fullness is judged on the pre-edge pointers, so a push to a full FIFO is
   // dropped even when a pop happens on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rxWrPtr_q <= '0;
         rxRdPtr_q <= '0;
         txWrPtr_q <= '0;
         txRdPtr_q <= '0;
      end else begin
         if (rxPush) rxWrPtr_q <= rxWrPtr_q + 1'b1;
         if (rxPop)  rxRdPtr_q <= rxRdPtr_q + 1'b1;
         if (txPush) txWrPtr_q <= txWrPtr_q + 1'b1;
         if (txPop)  txRdPtr_q <= txRdPtr_q + 1'b1;
      end
   end

   logic [31:0] led_q, digit_q;
   logic        rxIe_q, rxOvf_q, txOvf_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_q   <= '0;
         digit_q <= '0;
         rxIe_q  <= 1'b0;
         rxOvf_q <= 1'b0;
         txOvf_q <= 1'b0;
      end else begin
         if (periphWr && offset == OFF_LED)   led_q   <= bus.wdata;
         if (periphWr && offset == OFF_DIGIT) digit_q <= bus.wdata;
         if (periphWr && offset == OFF_CTRL)  rxIe_q  <= bus.wdata[0];
         rxOvf_q <= (rx_valid && rxFull) || (rxOvf_q && !(statWr && bus.wdata[4]));
         txOvf_q <= (txPushReq && txFull) || (txOvf_q && !(statWr && bus.wdata[5]));
      end
   end

   assign leds   = led_q;
   assign digits = digit_q;
   assign irq_rx = rxIe_q && !rxEmpty;

   logic [31:0]         reload_q [TIMER_CH];
   logic [31:0]         reload_d [TIMER_CH];
   logic [31:0]         count_q  [TIMER_CH];
   logic [31:0]         count_d  [TIMER_CH];
   logic [TIMER_CH-1:0] en_q, en_d, ie_q, ie_d, flag_q, flag_d;
   logic [TIMER_CH-1:0] reloadWr, countWr, ctrlWr, wrap;

   always_comb begin
      reloadWr = '0;
      countWr  = '0;
      ctrlWr   = '0;
      wrap     = '0;
      for (int k = 0; k < TIMER_CH; k++) begin
         reloadWr[k] = periphWr && (offset == timerBase(k));
         countWr[k]  = periphWr && (offset == timerBase(k) + 8'd4);
         ctrlWr[k]   = periphWr && (offset == timerBase(k) + 8'd8);
         wrap[k]     = en_q[k] && (count_q[k] == 32'hFFFF_FFFF);
      end
   end

   // A COUNT write overrides both increment and wrap; a wrap beats a flag clear.
   always_comb begin
      reload_d = reload_q;
      count_d  = count_q;
      en_d     = en_q;
      ie_d     = ie_q;
      flag_d   = flag_q;
      for (int k = 0; k < TIMER_CH; k++) begin
         if (reloadWr[k]) reload_d[k] = bus.wdata;
         if (countWr[k])   count_d[k] = bus.wdata;
         else if (wrap[k]) count_d[k] = reload_q[k];
         else if (en_q[k]) count_d[k] = count_q[k] + 32'd1;
         if (ctrlWr[k]) begin
            en_d[k] = bus.wdata[0];
            ie_d[k] = bus.wdata[1];
         end
         flag_d[k] = (wrap[k] && !countWr[k]) ||
                     (flag_q[k] && !(ctrlWr[k] && bus.wdata[2]));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reload_q <= '{default: '0};
         count_q  <= '{default: '0};
         en_q     <= '0;
         ie_q     <= '0;
         flag_q   <= '0;
      end else begin
         reload_q <= reload_d;
         count_q  <= count_d;
         en_q     <= en_d;
         ie_q     <= ie_d;
         flag_q   <= flag_d;
      end
   end

   assign irq_timer = flag_q & ie_q;

   logic [31:0] periphData;

   always_comb begin
      periphData = '0;
      case (offset)
         OFF_SYSCLK: periphData = clk_count;
         OFF_LED:    periphData = led_q;
         OFF_DIGIT:  periphData = digit_q;
         OFF_STAT:   periphData = {26'b0, txOvf_q, rxOvf_q, txEmpty, txFull, rxFull, !rxEmpty};
         OFF_RX:     if (!rxEmpty) periphData = {24'b0, rxMem[rxRdPtr_q[FIFO_AW-1:0]]};
         OFF_CTRL:   periphData = {31'b0, rxIe_q};
         default:    ;
      endcase
      for (int k = 0; k < TIMER_CH; k++) begin
         if (offset == timerBase(k))         periphData = reload_q[k];
         if (offset == timerBase(k) + 8'd4)  periphData = count_q[k];
         if (offset == timerBase(k) + 8'd8)  periphData = {29'b0, flag_q[k], ie_q[k], en_q[k]};
      end
   end

   // Load data is split by source so the RAM output register stays reset-free.
   logic [31:0] periphQ_q;
   logic        selRam_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         periphQ_q <= '0;
         selRam_q  <= 1'b0;
      end else if (bus.mem_read) begin
         selRam_q <= !isPeriph;
         if (isPeriph) periphQ_q <= periphData;
      end
   end

   assign bus.rdata = selRam_q ? ramQ_q : periphQ_q;
endmodule

// File: tb/tb_mmio_data_memory.sv
// Directed bench for mmio_data_memory: loads are checked through a scoreboard queue,
// sideband outputs (FIFO handshake, irqs, LEDs) are checked directly.
module tb_mmio_data_memory;
   localparam int          TIMER_CH = 2;
   localparam logic [31:0] P        = 32'h4000_0000;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic [31:0]         clkCount = 32'h0;
   logic [31:0]         leds, digits;
   logic [TIMER_CH-1:0] irq_timer;
   logic                irq_rx;
   logic                rx_valid = 1'b0;
   logic [7:0]          rx_data = 8'h0;
   logic                tx_valid;
   logic [7:0]          tx_data;
   logic                tx_ready = 1'b0;

   typedef struct {
      logic [31:0] expected;
      string       name;
   } sbItem_t;

   sbItem_t sbQueue[$];
   int      compared = 0;
   int      mismatched = 0;

   mmio_data_memory_if bus ();

   mmio_data_memory #(.RAM_AW(9), .TIMER_CH(TIMER_CH), .FIFO_AW(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .clk_count (clkCount),
      .leds      (leds),
      .digits    (digits),
      .irq_timer (irq_timer),
      .irq_rx    (irq_rx),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready)
   );

   initial forever #5 clk = ~clk;

   // Monitor: every load edge produces one rdata value that is checked against the queue head.
   initial begin
      sbItem_t item;
      forever begin
         @(posedge clk);
         if (bus.mem_read === 1'b1 && reset === 1'b0) begin
            #1;
            compared++;
            if (sbQueue.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL unexpected_load: rdata=%h with no expected value queued", bus.rdata);
            end else begin
               item = sbQueue.pop_front();
               if (bus.rdata !== item.expected) begin
                  mismatched++;
                  $display("[TB] FAIL %s: rdata=%h expected=%h", item.name, bus.rdata, item.expected);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic applyStimulus(input logic doRead, input logic doWrite, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] be,
                                input logic [31:0] expected, input string name);
      sbItem_t item;
      bus.addr      = addr;
      bus.wdata     = data;
      bus.be        = be;
      bus.mem_read  = doRead;
      bus.mem_write = doWrite;
      if (doRead) begin
         item.expected = expected;
         item.name     = name;
         sbQueue.push_back(item);
      end
      @(negedge clk);
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
   endtask

   task automatic writeWord(input logic [31:0] addr, input logic [31:0] data);
      applyStimulus(1'b0, 1'b1, addr, data, 4'hF, 32'h0, "");
   endtask

   task automatic readExpect(input logic [31:0] addr, input logic [31:0] expected, input string name);
      applyStimulus(1'b1, 1'b0, addr, 32'h0, 4'hF, expected, name);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic rxPulse(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   initial begin
      bus.addr      = 32'h0;
      bus.wdata     = 32'h0;
      bus.be        = 4'h0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] reset state");
      checkOutput("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
      checkOutput("reset_irqs", {29'b0, irq_rx, irq_timer}, 32'h0);
      checkOutput("reset_leds", leds, 32'h0);
      checkOutput("reset_rdata", bus.rdata, 32'h0);
      readExpect(P + 32'h0C, 32'h08, "reset_stat");

      $display("[TB] RAM");
      applyStimulus(1'b0, 1'b1, 32'h10, 32'hAABBCCDD, 4'hF, 32'h0, "");
      applyStimulus(1'b0, 1'b1, 32'h11, 32'h11223344, 4'b0101, 32'h0, "");
      readExpect(32'h10, 32'hAA22CC44, "ram_byte_enable");
      readExpect(32'h1000_0010, 32'hAA22CC44, "ram_upper_bits_ignored");
      writeWord(32'h800, 32'h12345678);
      readExpect(32'h0, 32'h12345678, "ram_wrap");
      writeWord(32'h20, 32'h11111111);
      applyStimulus(1'b1, 1'b1, 32'h20, 32'h22222222, 4'hF, 32'h11111111, "ram_read_first");
      readExpect(32'h20, 32'h22222222, "ram_after_write");

      $display("[TB] simple registers");
      applyStimulus(1'b0, 1'b1, P + 32'h04, 32'hDEADBEEF, 4'h0, 32'h0, "");
      checkOutput("led_ignores_be", leds, 32'hDEADBEEF);
      readExpect(P + 32'h04, 32'hDEADBEEF, "led_readback");
      writeWord(P + 32'h08, 32'h00C0FFEE);
      checkOutput("digits_port", digits, 32'h00C0FFEE);
      readExpect(P + 32'h08, 32'h00C0FFEE, "digit_readback");
      writeWord(P + 32'h1C, 32'h55);
      readExpect(P + 32'h1C, 32'h0, "unmapped_1c");
      readExpect(P + 32'h2C, 32'h0, "unmapped_2c");
      clkCount = 32'hC0FFEE01;
      readExpect(P + 32'h00, 32'hC0FFEE01, "sysclk");

      $display("[TB] timer 0");
      writeWord(P + 32'h20, 32'hFFFFFFFC);
      writeWord(P + 32'h24, 32'hFFFFFFFC);
      writeWord(P + 32'h28, 32'h3);
      repeat (3) @(negedge clk);
      checkOutput("t0_before_wrap", {30'b0, irq_timer}, 32'h0);
      @(negedge clk);
      checkOutput("t0_irq_after_wrap", {30'b0, irq_timer}, 32'h1);
      readExpect(P + 32'h24, 32'hFFFFFFFC, "t0_count_reloaded");
      writeWord(P + 32'h28, 32'h7);
      checkOutput("t0_flag_cleared", {30'b0, irq_timer}, 32'h0);
      readExpect(P + 32'h28, 32'h3, "t0_ctrl_en_kept");
      writeWord(P + 32'h28, 32'h7);
      checkOutput("t0_set_beats_clear", {30'b0, irq_timer}, 32'h1);
      writeWord(P + 32'h28, 32'h4);
      checkOutput("t0_disabled_irq", {30'b0, irq_timer}, 32'h0);
      readExpect(P + 32'h28, 32'h0, "t0_ctrl_off");
      readExpect(P + 32'h24, 32'hFFFFFFFD, "t0_count_holds");

      $display("[TB] timer 1");
      writeWord(P + 32'h30, 32'h5);
      writeWord(P + 32'h34, 32'hFFFFFFFE);
      writeWord(P + 32'h38, 32'h3);
      @(negedge clk);
      checkOutput("t1_before_wrap", {30'b0, irq_timer}, 32'h0);
      @(negedge clk);
      checkOutput("t1_irq_after_wrap", {30'b0, irq_timer}, 32'h2);
      readExpect(P + 32'h34, 32'h5, "t1_count_reloaded");
      writeWord(P + 32'h38, 32'h4);
      writeWord(P + 32'h34, 32'hFFFFFFFF);
      readExpect(P + 32'h34, 32'hFFFFFFFF, "t1_count_written");
      writeWord(P + 32'h38, 32'h3);
      writeWord(P + 32'h34, 32'h100);
      checkOutput("t1_write_beats_wrap", {30'b0, irq_timer}, 32'h0);
      readExpect(P + 32'h34, 32'h100, "t1_count_write_wins");
      writeWord(P + 32'h38, 32'h0);

      $display("[TB] TX FIFO");
      writeWord(P + 32'h14, 32'h41);
      writeWord(P + 32'h14, 32'h42);
      checkOutput("tx_valid_after_push", {31'b0, tx_valid}, 32'h1);
      checkOutput("tx_head_first", {24'b0, tx_data}, 32'h41);
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      checkOutput("tx_head_after_pop", {24'b0, tx_data}, 32'h42);
      tx_ready = 1'b1;
      writeWord(P + 32'h14, 32'h43);
      tx_ready = 1'b0;
      checkOutput("tx_push_pop_head", {24'b0, tx_data}, 32'h43);
      readExpect(P + 32'h0C, 32'h00, "tx_one_entry_stat");
      for (int i = 0; i < 16; i++) writeWord(P + 32'h14, 32'h50 + i);
      readExpect(P + 32'h0C, 32'h24, "tx_full_ovf_stat");
      tx_ready = 1'b1;
      repeat (15) @(negedge clk);
      tx_ready = 1'b0;
      checkOutput("tx_head_after_drain", {24'b0, tx_data}, 32'h5E);
      checkOutput("tx_valid_after_drain", {31'b0, tx_valid}, 32'h1);
      writeWord(P + 32'h0C, 32'h20);
      readExpect(P + 32'h0C, 32'h00, "tx_ovf_cleared");

      $display("[TB] RX FIFO");
      for (int i = 0; i < 17; i++) rxPulse(8'h60 + 8'(i));
      readExpect(P + 32'h0C, 32'h13, "rx_full_ovf_stat");
      for (int i = 0; i < 16; i++) readExpect(P + 32'h10, 32'h60 + i, "rx_pop_order");
      readExpect(P + 32'h10, 32'h0, "rx_read_empty");
      readExpect(P + 32'h0C, 32'h10, "rx_ovf_sticky");
      writeWord(P + 32'h0C, 32'h10);
      readExpect(P + 32'h0C, 32'h00, "rx_ovf_cleared");

      $display("[TB] irq_rx");
      writeWord(P + 32'h18, 32'h1);
      readExpect(P + 32'h18, 32'h1, "uart_ctrl_readback");
      rxPulse(8'hA5);
      checkOutput("irq_rx_set", {31'b0, irq_rx}, 32'h1);
      readExpect(P + 32'h10, 32'hA5, "rx_irq_byte");
      checkOutput("irq_rx_clear", {31'b0, irq_rx}, 32'h0);

      $display("[TB] reset mid-activity");
      writeWord(P + 32'h24, 32'hFFFFFFFE);
      writeWord(P + 32'h28, 32'h3);
      repeat (2) @(negedge clk);
      checkOutput("pre_reset_timer_irq", {30'b0, irq_timer}, 32'h1);
      rxPulse(8'h77);
      readExpect(P + 32'h04, 32'hDEADBEEF, "pre_reset_led_read");
      checkOutput("pre_reset_irq_rx", {31'b0, irq_rx}, 32'h1);
      checkOutput("pre_reset_tx_valid", {31'b0, tx_valid}, 32'h1);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_reset_tx_valid", {31'b0, tx_valid}, 32'h0);
      checkOutput("async_reset_irqs", {29'b0, irq_rx, irq_timer}, 32'h0);
      checkOutput("async_reset_leds", leds, 32'h0);
      checkOutput("async_reset_rdata", bus.rdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      readExpect(P + 32'h0C, 32'h08, "post_reset_stat");
      readExpect(P + 32'h18, 32'h0, "post_reset_uart_ctrl");
      readExpect(P + 32'h28, 32'h0, "post_reset_timer_ctrl");

      for (int i = 0; i < 10 && sbQueue.size() != 0; i++) @(negedge clk);
      if (sbQueue.size() != 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL scoreboard_drain: %0d loads still pending, expected 0", sbQueue.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
